// File: rtl/pulse_period_meter_if.sv
// rtl/pulse_period_meter_if.sv - result handshake bundle for pulse_period_meter
//
// Carries the measured result and its valid/ready handshake.
//   rd      consumer ready; a result is taken on valid & rd & clk_ena
//   period  last captured period, in enabled cycles
//   valid   period holds an unread result
//   ovf     captured period saturated
//   lost    at least one result was overwritten before being read
// master: the meter (drives the result); slave: the consumer (drives rd).

interface pulse_period_meter_if #(
    parameter int WIDTH = 16
);
    logic             rd;
    logic [WIDTH-1:0] period;
    logic             valid;
    logic             ovf;
    logic             lost;

    modport master (
        input  rd,
        output period,
        output valid,
        output ovf,
        output lost
    );

    modport slave (
        output rd,
        input  period,
        input  valid,
        input  ovf,
        input  lost
    );
endinterface

// File: rtl/pulse_period_meter.sv
// rtl/pulse_period_meter.sv - strobe rising-edge spacing meter with valid/ready result
//
// Counts enabled clock cycles between consecutive rising edges of strobe and
// presents each spacing on a valid/ready result port.
//   clk      system clock, rising edge
//   rst      asynchronous reset, active low
//   clk_ena  clock enable; every register, handshake included, holds when 0
//   srst     synchronous clear, qualified by clk_ena, beats everything else
//   strobe   measured signal; only its rising edge matters
//   res      result bundle (pulse_period_meter_if.master): rd in;
//            period, valid, ovf, lost out
// Optional feature: define PERIOD_METER_SYNC_EN to pass strobe through a
// 2-flop synchronizer for asynchronous sources (adds 2 enabled cycles of
// latency, periods unchanged).

module pulse_period_meter #(
    parameter int WIDTH = 16
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   clk_ena,
    input  logic                   srst,
    input  logic                   strobe,
    pulse_period_meter_if.master   res
);

    localparam logic [WIDTH-1:0] CNT_MAX = {WIDTH{1'b1}};
    localparam logic [WIDTH-1:0] CNT_ONE = {{(WIDTH-1){1'b0}}, 1'b1};

    typedef enum logic {
        IDLE = 1'b0,
        MEAS = 1'b1
    } state_t;

    state_t           state_q,    state_d;
    logic [WIDTH-1:0] cnt_q,      cnt_d;
    logic             ovf_run_q,  ovf_run_d;
    logic             strobe_d_q, strobe_d_d;
    logic [WIDTH-1:0] period_q,   period_d;
    logic             valid_q,    valid_d;
    logic             ovf_q,      ovf_d;
    logic             lost_q,     lost_d;

    logic             strobe_s;
    logic             strobe_rise;
    logic             accept;
    logic             capture;
    logic [WIDTH-1:0] cnt_inc;

`ifdef PERIOD_METER_SYNC_EN
    // Two-stage synchronizer; cleared by srst so a held-high strobe re-edges
    // exactly like it does after an asynchronous reset.
    logic [1:0] sync_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sync_q <= 2'b00;
        end else if (clk_ena) begin
            if (srst) begin
                sync_q <= 2'b00;
            end else begin
                sync_q <= {sync_q[0], strobe};
            end
        end
    end

    assign strobe_s = sync_q[1];
`else
    assign strobe_s = strobe;
`endif

    // strobe_d_q starts at 0, so a strobe already high at reset release is an edge.
    assign strobe_rise = strobe_s & ~strobe_d_q;
    assign accept      = valid_q & res.rd;
    assign capture     = (state_q == MEAS) & strobe_rise;
    assign cnt_inc     = cnt_q + CNT_ONE;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            ovf_run_q  <= 1'b0;
            strobe_d_q <= 1'b0;
            period_q   <= '0;
            valid_q    <= 1'b0;
            ovf_q      <= 1'b0;
            lost_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            ovf_run_q  <= ovf_run_d;
            strobe_d_q <= strobe_d_d;
            period_q   <= period_d;
            valid_q    <= valid_d;
            ovf_q      <= ovf_d;
            lost_q     <= lost_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        ovf_run_d  = ovf_run_q;
        strobe_d_d = strobe_d_q;
        period_d   = period_q;
        valid_d    = valid_q;
        ovf_d      = ovf_q;
        lost_d     = lost_q;

        if (clk_ena) begin
            if (srst) begin
                state_d    = IDLE;
                cnt_d      = '0;
                ovf_run_d  = 1'b0;
                strobe_d_d = 1'b0;
                period_d   = '0;
                valid_d    = 1'b0;
                ovf_d      = 1'b0;
                lost_d     = 1'b0;
            end else begin
                strobe_d_d = strobe_s;

                case (state_q)
                    IDLE: begin
                        // First edge only arms the counter; nothing to capture yet.
                        if (strobe_rise) begin
                            state_d = MEAS;
                            cnt_d   = CNT_ONE;
                        end
                    end
                    MEAS: begin
                        if (strobe_rise) begin
                            period_d  = cnt_q;
                            ovf_d     = ovf_run_q;
                            cnt_d     = CNT_ONE;
                            ovf_run_d = 1'b0;
                        end else if (cnt_q != CNT_MAX) begin
                            cnt_d = cnt_inc;
                            // Flag is raised as the count lands on all-ones and
                            // stays up while the count is pinned there.
                            if (cnt_inc == CNT_MAX) begin
                                ovf_run_d = 1'b1;
                            end
                        end
                    end
                    default: begin
                        state_d = IDLE;
                    end
                endcase

                if (capture) begin
                    valid_d = 1'b1;
                    // An overwrite of an unread result is only a loss if the
                    // consumer did not take the old one in this same cycle.
                    if (accept) begin
                        lost_d = 1'b0;
                    end else if (valid_q) begin
                        lost_d = 1'b1;
                    end
                end else if (accept) begin
                    valid_d = 1'b0;
                    lost_d  = 1'b0;
                end
            end
        end
    end

    assign res.period = period_q;
    assign res.valid  = valid_q;
    assign res.ovf    = ovf_q;
    assign res.lost   = lost_q;

endmodule

// File: tb/tb_pulse_period_meter.sv
// tb/tb_pulse_period_meter.sv - self-checking bench for pulse_period_meter (WIDTH 16 and 4)

module tb_pulse_period_meter;

    logic clk = 1'b0;
    logic rst;
    logic clk_ena;
    logic srst;
    logic strobe;
    logic rd;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    pulse_period_meter_if #(.WIDTH(16)) bus16 ();
    pulse_period_meter_if #(.WIDTH(4))  bus4  ();

    assign bus16.rd = rd;
    assign bus4.rd  = rd;

    pulse_period_meter #(.WIDTH(16)) dut16 (
        .clk     (clk),
        .rst     (rst),
        .clk_ena (clk_ena),
        .srst    (srst),
        .strobe  (strobe),
        .res     (bus16.master)
    );

    pulse_period_meter #(.WIDTH(4)) dut4 (
        .clk     (clk),
        .rst     (rst),
        .clk_ena (clk_ena),
        .srst    (srst),
        .strobe  (strobe),
        .res     (bus4.master)
    );

    // Reference model: remembers the enabled-cycle index of the last edge and
    // derives each period as the difference, clipped at 2^WIDTH-1.
    int   mx[2] = '{65535, 15};
    int   ecnt;
    bit   prev[2];
    bit   armed[2];
    int   last[2];
    int   m_period[2];
    bit   m_valid[2];
    bit   m_ovf[2];
    bit   m_lost[2];

    task automatic model_reset();
        for (int i = 0; i < 2; i++) begin
            prev[i] = 0; armed[i] = 0; last[i] = 0;
            m_period[i] = 0; m_valid[i] = 0; m_ovf[i] = 0; m_lost[i] = 0;
        end
    endtask

    task automatic model_clock();
        bit e;
        bit acc;
        int sp;
        if (rst && clk_ena) begin
            for (int i = 0; i < 2; i++) begin
                if (srst) begin
                    prev[i] = 0; armed[i] = 0;
                    m_period[i] = 0; m_valid[i] = 0; m_ovf[i] = 0; m_lost[i] = 0;
                end else begin
                    e   = strobe & !prev[i];
                    prev[i] = strobe;
                    acc = m_valid[i] & rd;
                    if (e && armed[i]) begin
                        sp = ecnt - last[i];
                        m_period[i] = (sp >= mx[i]) ? mx[i] : sp;
                        m_ovf[i]    = (sp >= mx[i]);
                        if (acc) m_lost[i] = 0;
                        else if (m_valid[i]) m_lost[i] = 1;
                        m_valid[i] = 1;
                    end else if (acc) begin
                        m_valid[i] = 0;
                        m_lost[i]  = 0;
                    end
                    if (e) begin
                        armed[i] = 1;
                        last[i]  = ecnt;
                    end
                end
            end
            ecnt++;
        end
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_all();
        chk("w16_period", {16'b0, bus16.period}, m_period[0]);
        chk("w16_valid",  {31'b0, bus16.valid},  {31'b0, m_valid[0]});
        chk("w16_ovf",    {31'b0, bus16.ovf},    {31'b0, m_ovf[0]});
        chk("w16_lost",   {31'b0, bus16.lost},   {31'b0, m_lost[0]});
        chk("w4_period",  {28'b0, bus4.period},  m_period[1]);
        chk("w4_valid",   {31'b0, bus4.valid},   {31'b0, m_valid[1]});
        chk("w4_ovf",     {31'b0, bus4.ovf},     {31'b0, m_ovf[1]});
        chk("w4_lost",    {31'b0, bus4.lost},    {31'b0, m_lost[1]});
    endtask

    task automatic tick();
        @(posedge clk);
        model_clock();
        #1;
        check_all();
    endtask

    task automatic pulse_gap(input int n);
        strobe = 1'b1;
        tick();
        strobe = 1'b0;
        repeat (n - 1) tick();
    endtask

    task automatic en_tick(input bit s);
        strobe  = s;
        clk_ena = 1'b0;
        tick();
        clk_ena = 1'b1;
        tick();
    endtask

    int hold;
    int mod7;

    initial begin
        rst = 1'b0; clk_ena = 1'b1; srst = 1'b0; strobe = 1'b0; rd = 1'b1;
        ecnt = 0;
        model_reset();
        #1;
        check_all();
        repeat (3) tick();
        #2 rst = 1'b1;

        // Modulo-7 counter carry, consumer always ready.
        mod7 = 0;
        repeat (60) begin
            strobe = (mod7 == 6);
            tick();
            mod7 = (mod7 == 6) ? 0 : mod7 + 1;
        end
        strobe = 1'b0;
        chk("mod7_period", {16'b0, bus16.period}, 32'd7);
        chk("mod7_ovf",    {31'b0, bus16.ovf},    32'd0);

        // Saturation on the narrow instance: 20 apart, then 9 apart.
        pulse_gap(20);
        pulse_gap(20);
        pulse_gap(9);
        strobe = 1'b1; tick(); strobe = 1'b0;
        chk("w4_sat_then_9", {28'b0, bus4.period}, 32'd9);
        chk("w4_sat_then_9_ovf", {31'b0, bus4.ovf}, 32'd0);
        repeat (3) tick();

        // Boundary spacings around the narrow saturation point.
        pulse_gap(14);
        pulse_gap(15);
        pulse_gap(16);
        pulse_gap(2);
        strobe = 1'b1; tick(); strobe = 1'b0; tick();

        // Overwrite without read, then one read.
        rd = 1'b0;
        pulse_gap(5);
        pulse_gap(6);
        strobe = 1'b1; tick(); strobe = 1'b0; tick();
        chk("lost_period", {16'b0, bus16.period}, 32'd6);
        chk("lost_flag",   {31'b0, bus16.lost},   32'd1);
        chk("lost_valid",  {31'b0, bus16.valid},  32'd1);
        rd = 1'b1; tick();
        chk("read_valid",  {31'b0, bus16.valid},  32'd0);
        chk("read_lost",   {31'b0, bus16.lost},   32'd0);

        // Capture and accept in the same cycle.
        pulse_gap(4);
        strobe = 1'b1; tick(); strobe = 1'b0; tick();

        // Alternating clock enable, 10 enabled cycles between edges.
        repeat (3) begin
            en_tick(1'b1);
            repeat (9) en_tick(1'b0);
        end
        en_tick(1'b1);
        en_tick(1'b0);
        chk("ena_period", {16'b0, bus16.period}, 32'd10);

        // Asynchronous reset mid-count.
        pulse_gap(3);
        repeat (2) tick();
        #2 rst = 1'b0;
        #1;
        model_reset();
        check_all();
        tick();
        #2 rst = 1'b1;
        pulse_gap(4);
        chk("rearm_no_valid", {31'b0, bus16.valid}, 32'd0);
        strobe = 1'b1; tick(); strobe = 1'b0; tick();
        chk("rearm_period", {16'b0, bus16.period}, 32'd4);

        // Synchronous clear with a result pending.
        rd = 1'b0;
        pulse_gap(5);
        strobe = 1'b1; tick(); strobe = 1'b0;
        srst = 1'b1; tick(); srst = 1'b0;
        chk("srst_valid",  {31'b0, bus16.valid},  32'd0);
        chk("srst_period", {16'b0, bus16.period}, 32'd0);
        pulse_gap(3);
        strobe = 1'b1; tick(); strobe = 1'b0; tick();
        chk("srst_rearm", {16'b0, bus16.period}, 32'd3);
        rd = 1'b1;

        // Randomized levels, handshake, enable and clears.
        hold = 0;
        repeat (1500) begin
            if (hold == 0) begin
                strobe = ($urandom % 3 == 0);
                hold   = $urandom_range(1, 12);
                if ($urandom % 25 == 0) hold = $urandom_range(15, 40);
            end
            hold--;
            rd      = ($urandom % 3 != 0);
            clk_ena = ($urandom % 5 != 0);
            srst    = ($urandom % 120 == 0);
            tick();
        end
        clk_ena = 1'b1; srst = 1'b0; strobe = 1'b0;
        tick();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
